ecc_scrub: RTL and testbench

ECC_SCRUB -- requirements
Module: ecc_scrub

---
 rtl/ecc_scrub.sv | 201 ++++++++++++++++++++
 tb/tb_ecc_scrub.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_scrub.sv
// Background memory scrubber: reads every address in turn, tallies decoder errors and,
// when ECC_SCRUB_WRITEBACK_EN is defined, writes corrected data back on single-bit errors.
module ecc_scrub #(
  parameter int unsigned K  = 8,
  parameter int unsigned AW = 10,
  parameter int unsigned CW = 16,
  parameter int unsigned IW = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_i,
  input  logic          clr_i,
  input  logic [IW-1:0] interval_i,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_adr_o,
  output logic [K-1:0]  mem_d_o,
  input  logic          mem_ack_i,
  input  logic          dec_vld_i,
  input  logic [K-1:0]  dec_q_i,
  input  logic          dec_sb_err_i,
  input  logic          dec_db_err_i,
  output logic          busy_o,
  output logic          pass_done_o,
  output logic [CW-1:0] sb_cnt_o,
  output logic [CW-1:0] db_cnt_o,
  output logic [AW-1:0] db_adr_o,
  output logic          db_irq_o
);

  localparam logic [AW-1:0] ADR_LAST = {AW{1'b1}};
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_READ  = 3'd2,
    ST_CHECK = 3'd3,
`ifdef ECC_SCRUB_WRITEBACK_EN
    ST_WRITE = 3'd4,
`endif
    ST_NEXT  = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] timer_q, timer_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [CW-1:0] sb_cnt_q, sb_cnt_d;
  logic [CW-1:0] db_cnt_q, db_cnt_d;
  logic [AW-1:0] db_adr_q, db_adr_d;
  logic          irq_q, irq_d;
  logic          req_q, req_d;
  logic          busy_q, busy_d;
  logic          pass_q, pass_d;
`ifdef ECC_SCRUB_WRITEBACK_EN
  logic          we_q, we_d;
  logic [K-1:0]  mem_d_q, mem_d_d;
`else
  logic [K-1:0]  unused_dec_q;
  assign unused_dec_q = dec_q_i;
`endif

  // Next-state, counter and registered-output logic.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    adr_d    = adr_q;
    sb_cnt_d = sb_cnt_q;
    db_cnt_d = db_cnt_q;
    db_adr_d = db_adr_q;
    irq_d    = irq_q;
`ifdef ECC_SCRUB_WRITEBACK_EN
    mem_d_d  = mem_d_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (en_i) begin
          state_d = ST_WAIT;
          timer_d = interval_i;
        end
      end
      ST_WAIT: begin
        if (!en_i) begin
          state_d = ST_IDLE;
        end else if (timer_q == '0) begin
          state_d = ST_READ;
        end else begin
          timer_d = timer_q - IW'(1);
        end
      end
      ST_READ: begin
        if (mem_ack_i) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (dec_vld_i) begin
          if (dec_db_err_i) begin
            if (db_cnt_q != CNT_MAX) db_cnt_d = db_cnt_q + CW'(1);
            db_adr_d = adr_q;
            irq_d    = 1'b1;
            state_d  = ST_NEXT;
          end else if (dec_sb_err_i) begin
            if (sb_cnt_q != CNT_MAX) sb_cnt_d = sb_cnt_q + CW'(1);
`ifdef ECC_SCRUB_WRITEBACK_EN
            mem_d_d = dec_q_i;
            state_d = ST_WRITE;
`else
            state_d = ST_NEXT;
`endif
          end else begin
            state_d = ST_NEXT;
          end
        end
      end
`ifdef ECC_SCRUB_WRITEBACK_EN
      ST_WRITE: begin
        if (mem_ack_i) state_d = ST_NEXT;
      end
`endif
      ST_NEXT: begin
        adr_d = adr_q + AW'(1);
        if (en_i) begin
          state_d = ST_WAIT;
          timer_d = interval_i;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Clear wins over any same-cycle update of the error bookkeeping.
    if (clr_i) begin
      sb_cnt_d = '0;
      db_cnt_d = '0;
      db_adr_d = '0;
      irq_d    = 1'b0;
    end

`ifdef ECC_SCRUB_WRITEBACK_EN
    req_d = (state_d == ST_READ) || (state_d == ST_WRITE);
    we_d  = (state_d == ST_WRITE);
`else
    req_d = (state_d == ST_READ);
`endif
    busy_d = (state_d != ST_IDLE);
    // The address only advances when leaving NEXT, so adr_q is the one being finished.
    pass_d = (state_d == ST_NEXT) && (adr_q == ADR_LAST);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      adr_q    <= '0;
      sb_cnt_q <= '0;
      db_cnt_q <= '0;
      db_adr_q <= '0;
      irq_q    <= 1'b0;
      req_q    <= 1'b0;
      busy_q   <= 1'b0;
      pass_q   <= 1'b0;
`ifdef ECC_SCRUB_WRITEBACK_EN
      we_q     <= 1'b0;
      mem_d_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      adr_q    <= adr_d;
      sb_cnt_q <= sb_cnt_d;
      db_cnt_q <= db_cnt_d;
      db_adr_q <= db_adr_d;
      irq_q    <= irq_d;
      req_q    <= req_d;
      busy_q   <= busy_d;
      pass_q   <= pass_d;
`ifdef ECC_SCRUB_WRITEBACK_EN
      we_q     <= we_d;
      mem_d_q  <= mem_d_d;
`endif
    end
  end

  assign mem_req_o   = req_q;
  assign mem_adr_o   = adr_q;
  assign busy_o      = busy_q;
  assign pass_done_o = pass_q;
  assign sb_cnt_o    = sb_cnt_q;
  assign db_cnt_o    = db_cnt_q;
  assign db_adr_o    = db_adr_q;
  assign db_irq_o    = irq_q;
`ifdef ECC_SCRUB_WRITEBACK_EN
  assign mem_we_o    = we_q;
  assign mem_d_o     = mem_d_q;
`else
  assign mem_we_o    = 1'b0;
  assign mem_d_o     = '0;
`endif

endmodule

// File: tb/tb_ecc_scrub.sv
// Randomized scrub-slot bench for ecc_scrub; the bench plays memory and decoder and keeps
// a transaction-level model of address order, counters and write-back data.
module tb_ecc_scrub;

  localparam int unsigned K  = 8;
  localparam int unsigned AW = 3;
  localparam int unsigned CW = 3;
  localparam int unsigned IW = 4;
  localparam int NADR = 8;
  localparam int SAT  = 7;
`ifdef ECC_SCRUB_WRITEBACK_EN
  localparam bit WB = 1'b1;
`else
  localparam bit WB = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          en_i = 1'b0;
  logic          clr_i = 1'b0;
  logic [IW-1:0] interval_i = '0;
  logic          mem_req_o, mem_we_o;
  logic [AW-1:0] mem_adr_o;
  logic [K-1:0]  mem_d_o;
  logic          mem_ack_i = 1'b0;
  logic          dec_vld_i = 1'b0;
  logic [K-1:0]  dec_q_i = '0;
  logic          dec_sb_err_i = 1'b0;
  logic          dec_db_err_i = 1'b0;
  logic          busy_o, pass_done_o, db_irq_o;
  logic [CW-1:0] sb_cnt_o, db_cnt_o;
  logic [AW-1:0] db_adr_o;

  ecc_scrub #(.K(K), .AW(AW), .CW(CW), .IW(IW)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .en_i         (en_i),
    .clr_i        (clr_i),
    .interval_i   (interval_i),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_adr_o    (mem_adr_o),
    .mem_d_o      (mem_d_o),
    .mem_ack_i    (mem_ack_i),
    .dec_vld_i    (dec_vld_i),
    .dec_q_i      (dec_q_i),
    .dec_sb_err_i (dec_sb_err_i),
    .dec_db_err_i (dec_db_err_i),
    .busy_o       (busy_o),
    .pass_done_o  (pass_done_o),
    .sb_cnt_o     (sb_cnt_o),
    .db_cnt_o     (db_cnt_o),
    .db_adr_o     (db_adr_o),
    .db_irq_o     (db_irq_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state
  int         exp_adr = 0;
  int         exp_sb  = 0;
  int         exp_db  = 0;
  int         exp_db_adr = 0;
  bit         exp_irq = 1'b0;
  logic [7:0] exp_memd = 8'h00;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  // Withhold the ack for dly cycles, checking the request stays put, then ack once.
  task automatic handshake(input int dly, input bit we, input logic [7:0] d);
    bit held;
    held = 1'b1;
    for (int i = 0; i < dly; i++) begin
      tick();
      if (!mem_req_o || mem_we_o !== we || mem_adr_o !== AW'(exp_adr) ||
          (we && mem_d_o !== d)) held = 1'b0;
    end
    chk(we ? "wr_hold" : "rd_hold", {31'd0, held}, 32'd1);
    mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
    chk(we ? "wr_req_drop" : "rd_req_drop", {31'd0, mem_req_o}, 32'd0);
  endtask

  // One scrub of one address, starting at a negedge in IDLE or NEXT and ending in NEXT
  // (or one cycle later in IDLE when en_i is dropped mid-slot).
  task automatic slot(input int ival, input int ack_dly, input int vld_dly, input int err,
                      input logic [7:0] q, input bit clr, input bit drop);
    int cnt;
    bit quiet;
    interval_i = IW'(ival);
    en_i = 1'b1;
    cnt = 0;
    quiet = 1'b1;
    do begin
      // Decoder noise outside CHECK must be ignored.
      dec_vld_i    = 1'($urandom_range(0, 1));
      dec_sb_err_i = 1'($urandom_range(0, 1));
      dec_db_err_i = 1'($urandom_range(0, 1));
      dec_q_i      = 8'($urandom);
      tick();
      cnt++;
      if (pass_done_o) quiet = 1'b0;
    end while (!mem_req_o && cnt < 100);
    dec_vld_i = 1'b0;
    dec_sb_err_i = 1'b0;
    dec_db_err_i = 1'b0;
    chk("rd_latency", cnt, ival + 2);
    chk("pass_quiet", {31'd0, quiet}, 32'd1);
    chk("rd_we", {31'd0, mem_we_o}, 32'd0);
    chk("rd_adr", {29'd0, mem_adr_o}, exp_adr);
    if (drop) en_i = 1'b0;
    handshake(ack_dly, 1'b0, 8'h00);

    for (int i = 0; i < vld_dly; i++) begin
      dec_sb_err_i = 1'($urandom_range(0, 1));
      dec_db_err_i = 1'($urandom_range(0, 1));
      tick();
    end
    dec_vld_i    = 1'b1;
    dec_db_err_i = (err == 2);
    dec_sb_err_i = (err == 1) || (err == 2 && $urandom_range(0, 1) == 1);
    dec_q_i      = q;
    clr_i        = clr;
    tick();
    dec_vld_i = 1'b0;
    dec_sb_err_i = 1'b0;
    dec_db_err_i = 1'b0;
    clr_i = 1'b0;

    if (err == 2) begin
      if (exp_db < SAT) exp_db++;
      exp_db_adr = exp_adr;
      exp_irq = 1'b1;
    end else if (err == 1) begin
      if (exp_sb < SAT) exp_sb++;
      if (WB) exp_memd = q;
    end
    if (clr) begin
      exp_sb = 0;
      exp_db = 0;
      exp_db_adr = 0;
      exp_irq = 1'b0;
    end

    if (WB && err == 1) begin
      chk("wr_req", {31'd0, mem_req_o}, 32'd1);
      chk("wr_we", {31'd0, mem_we_o}, 32'd1);
      chk("wr_adr", {29'd0, mem_adr_o}, exp_adr);
      chk("wr_data", {24'd0, mem_d_o}, {24'd0, q});
      handshake(ack_dly, 1'b1, q);
    end else begin
      chk("no_write", {30'd0, mem_req_o, mem_we_o}, 32'd0);
    end

    chk("pass_done", {31'd0, pass_done_o}, (exp_adr == NADR - 1) ? 32'd1 : 32'd0);
    chk("busy_next", {31'd0, busy_o}, 32'd1);
    chk("sb_cnt", {29'd0, sb_cnt_o}, exp_sb);
    chk("db_cnt", {29'd0, db_cnt_o}, exp_db);
    chk("db_adr", {29'd0, db_adr_o}, exp_db_adr);
    chk("db_irq", {31'd0, db_irq_o}, {31'd0, exp_irq});
    chk("mem_d", {24'd0, mem_d_o}, {24'd0, exp_memd});
    exp_adr = (exp_adr + 1) % NADR;
    if (drop) begin
      tick();
      chk("idle_busy", {31'd0, busy_o}, 32'd0);
      chk("idle_adr", {29'd0, mem_adr_o}, exp_adr);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int cnt;
    repeat (3) tick();
    rst_ni = 1'b1;
    tick();
    chk("rst_req", {31'd0, mem_req_o}, 32'd0);
    chk("rst_we", {31'd0, mem_we_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_pass", {31'd0, pass_done_o}, 32'd0);
    chk("rst_irq", {31'd0, db_irq_o}, 32'd0);
    chk("rst_adr", {29'd0, mem_adr_o}, 32'd0);
    chk("rst_mem_d", {24'd0, mem_d_o}, 32'd0);
    chk("rst_sb", {29'd0, sb_cnt_o}, 32'd0);
    chk("rst_db", {29'd0, db_cnt_o}, 32'd0);
    chk("rst_db_adr", {29'd0, db_adr_o}, 32'd0);

    // Dropping enable while waiting returns to IDLE without a read.
    interval_i = IW'(8);
    en_i = 1'b1;
    repeat (3) tick();
    chk("wait_busy", {31'd0, busy_o}, 32'd1);
    en_i = 1'b0;
    tick();
    chk("wait_abort_busy", {31'd0, busy_o}, 32'd0);
    chk("wait_abort_req", {31'd0, mem_req_o}, 32'd0);

    slot(3, 0, 0, 0, 8'h00, 1'b0, 1'b0);
    slot(0, 5, 1, 0, 8'h00, 1'b0, 1'b1);
    for (int n = 0; n < 70; n++) begin
      slot($urandom_range(0, 5), $urandom_range(0, 4), $urandom_range(0, 3),
           $urandom_range(0, 2), 8'($urandom), $urandom_range(0, 9) == 0,
           $urandom_range(0, 7) == 0);
    end
    for (int n = 0; n < 9; n++) slot(0, 1, 0, 1, 8'hA5, 1'b0, 1'b0);
    chk("sb_saturated", {29'd0, sb_cnt_o}, SAT);
    slot(1, 2, 0, 2, 8'h3C, 1'b0, 1'b1);

    // Clear while idle wipes counters, captured address and interrupt.
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    exp_sb = 0;
    exp_db = 0;
    exp_db_adr = 0;
    exp_irq = 1'b0;
    chk("clr_sb", {29'd0, sb_cnt_o}, exp_sb);
    chk("clr_db", {29'd0, db_cnt_o}, exp_db);
    chk("clr_db_adr", {29'd0, db_adr_o}, exp_db_adr);
    chk("clr_irq", {31'd0, db_irq_o}, {31'd0, exp_irq});
    chk("clr_keeps_adr", {29'd0, mem_adr_o}, exp_adr);

    // Reset in the middle of a pending read drops the request at once.
    interval_i = '0;
    en_i = 1'b1;
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!mem_req_o && cnt < 100);
    chk("pre_rst_req", {31'd0, mem_req_o}, 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    chk("async_rst_req", {31'd0, mem_req_o}, 32'd0);
    chk("async_rst_busy", {31'd0, busy_o}, 32'd0);
    chk("async_rst_adr", {29'd0, mem_adr_o}, 32'd0);
    en_i = 1'b0;
    tick();
    rst_ni = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
